// File: rtl/video_timing_gen.sv
// video_timing_gen: parametrised raster timing generator for arcade cores.
//
// Free-running horizontal/vertical counters advance on clk_sys edges where ce_pix is high.
// Blank and sync flags are registered from the next counter values, so they always describe
// the position currently shown on hpos/vpos. rgb_out is the blanked, registered pixel.
//
// Optional feature macro: VTG_FLIP_EN adds the flip input (cocktail-mode mirrored positions).
//
// Ports:
//   clk_sys    in          sole clock
//   reset_n    in          asynchronous active-low reset
//   ce_pix     in          pixel clock enable
//   flip       in          mirror active-area positions (only with VTG_FLIP_EN)
//   rgb_in     in  RGBW    pixel for the current hpos/vpos
//   hpos/vpos  out CW      position presented to the core
//   rgb_out    out RGBW    registered pixel, forced to 0 while blanked
//   hblank     out         horizontal blank, active high
//   vblank     out         vertical blank, active high
//   hsync_n    out         horizontal sync, active low
//   vsync_n    out         vertical sync, active low
//   vbl_irq    out         single clk_sys pulse at vblank start
//   frame_cnt  out 8       completed frames, wraps at 255
module video_timing_gen #(
    parameter int unsigned CW           = 9,
    parameter int unsigned RGBW         = 12,
    parameter int unsigned H_ACTIVE     = 288,
    parameter int unsigned H_SYNC_START = 312,
    parameter int unsigned H_SYNC_END   = 343,
    parameter int unsigned H_TOTAL      = 384,
    parameter int unsigned V_ACTIVE     = 224,
    parameter int unsigned V_SYNC_START = 227,
    parameter int unsigned V_SYNC_END   = 234,
    parameter int unsigned V_TOTAL      = 263
) (
    input  logic            clk_sys,
    input  logic            reset_n,
    input  logic            ce_pix,
`ifdef VTG_FLIP_EN
    input  logic            flip,
`endif
    input  logic [RGBW-1:0] rgb_in,
    output logic [CW-1:0]   hpos,
    output logic [CW-1:0]   vpos,
    output logic [RGBW-1:0] rgb_out,
    output logic            hblank,
    output logic            vblank,
    output logic            hsync_n,
    output logic            vsync_n,
    output logic            vbl_irq,
    output logic [7:0]      frame_cnt
);

    localparam longint unsigned CNT_RANGE = 64'd1 << CW;

    if (!(H_ACTIVE < H_SYNC_START && H_SYNC_START < H_SYNC_END && H_SYNC_END <= H_TOTAL &&
          64'(H_TOTAL) <= CNT_RANGE)) begin : g_bad_h_geom
        $error("video_timing_gen: illegal horizontal geometry");
    end
    if (!(V_ACTIVE < V_SYNC_START && V_SYNC_START < V_SYNC_END && V_SYNC_END <= V_TOTAL &&
          64'(V_TOTAL) <= CNT_RANGE)) begin : g_bad_v_geom
        $error("video_timing_gen: illegal vertical geometry");
    end

    // Comparisons use one extra bit so a sync end equal to 2**CW stays representable.
    localparam int unsigned XW = CW + 1;
    localparam logic [XW-1:0] H_ACT_X = XW'(H_ACTIVE);
    localparam logic [XW-1:0] H_SS_X  = XW'(H_SYNC_START);
    localparam logic [XW-1:0] H_SE_X  = XW'(H_SYNC_END);
    localparam logic [XW-1:0] V_ACT_X = XW'(V_ACTIVE);
    localparam logic [XW-1:0] V_SS_X  = XW'(V_SYNC_START);
    localparam logic [XW-1:0] V_SE_X  = XW'(V_SYNC_END);
    localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] V_IRQ   = CW'(V_ACTIVE - 1);

    logic [CW-1:0]   r_hcnt;
    logic [CW-1:0]   r_vcnt;
    logic [RGBW-1:0] r_rgb;
    logic            r_hblank;
    logic            r_vblank;
    logic            r_hsync_n;
    logic            r_vsync_n;
    logic            r_vbl_irq;
    logic [7:0]      r_frame_cnt;

    logic            w_hwrap;
    logic            w_vwrap;
    logic [CW-1:0]   w_hn;
    logic [CW-1:0]   w_vn;
    logic [XW-1:0]   w_hx;
    logic [XW-1:0]   w_vx;

    assign w_hwrap = (r_hcnt == H_LAST);
    assign w_vwrap = (r_vcnt == V_LAST);
    assign w_hn    = w_hwrap ? '0 : r_hcnt + CW'(1);
    assign w_vn    = w_hwrap ? (w_vwrap ? '0 : r_vcnt + CW'(1)) : r_vcnt;
    assign w_hx    = {1'b0, w_hn};
    assign w_vx    = {1'b0, w_vn};

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_hcnt      <= '0;
            r_vcnt      <= '0;
            r_rgb       <= '0;
            r_hblank    <= 1'b1;
            r_vblank    <= 1'b1;
            r_hsync_n   <= 1'b1;
            r_vsync_n   <= 1'b1;
            r_vbl_irq   <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            // Pulse lasts one clk_sys regardless of how sparse ce_pix is.
            r_vbl_irq <= 1'b0;
            if (ce_pix) begin
                r_hcnt    <= w_hn;
                r_vcnt    <= w_vn;
                r_hblank  <= (w_hx >= H_ACT_X);
                r_vblank  <= (w_vx >= V_ACT_X);
                r_hsync_n <= !((w_hx >= H_SS_X) && (w_hx < H_SE_X));
                r_vsync_n <= !((w_vx >= V_SS_X) && (w_vx < V_SE_X));
                // Current flags describe the pixel whose rgb_in is on the bus now.
                r_rgb     <= (r_hblank || r_vblank) ? '0 : rgb_in;
                r_vbl_irq <= w_hwrap && (r_vcnt == V_IRQ);
                if (w_hwrap && w_vwrap) begin
                    r_frame_cnt <= r_frame_cnt + 8'd1;
                end
            end
        end
    end

`ifdef VTG_FLIP_EN
    localparam logic [CW-1:0] H_ACT_M1 = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] V_ACT_M1 = CW'(V_ACTIVE - 1);

    // Only the active area is mirrored; blanking positions pass through unchanged.
    always_comb begin
        hpos = r_hcnt;
        vpos = r_vcnt;
        if (flip && ({1'b0, r_hcnt} < H_ACT_X)) begin
            hpos = H_ACT_M1 - r_hcnt;
        end
        if (flip && ({1'b0, r_vcnt} < V_ACT_X)) begin
            vpos = V_ACT_M1 - r_vcnt;
        end
    end
`else
    assign hpos = r_hcnt;
    assign vpos = r_vcnt;
`endif

    assign rgb_out   = r_rgb;
    assign hblank    = r_hblank;
    assign vblank    = r_vblank;
    assign hsync_n   = r_hsync_n;
    assign vsync_n   = r_vsync_n;
    assign vbl_irq   = r_vbl_irq;
    assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen. The reference model derives every expected output
// from the absolute number of ce_pix pulses since reset using plain division/modulo.
// Three instances: default geometry, a tiny geometry (CW=4) for whole-frame and wrap tests, and
// a CW=10 / 640-pixel-line geometry.
module tb_video_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int ha; int hss; int hse; int ht;
        int va; int vss; int vse; int vt;
    } geom_t;

    geom_t g_def, g_sml, g_wid;

    // Default instance
    logic        d_rst_n, d_ce;
    logic [11:0] d_rgb_in, d_rgb_out;
    logic [8:0]  d_hpos, d_vpos;
    logic        d_hb, d_vb, d_hs, d_vs, d_irq;
    logic [7:0]  d_fc;
    // Small instance
    logic        s_rst_n, s_ce;
    logic [11:0] s_rgb_in, s_rgb_out;
    logic [3:0]  s_hpos, s_vpos;
    logic        s_hb, s_vb, s_hs, s_vs, s_irq;
    logic [7:0]  s_fc;
    // Wide instance
    logic        w_rst_n, w_ce;
    logic [11:0] w_rgb_in, w_rgb_out;
    logic [9:0]  w_hpos, w_vpos;
    logic        w_hb, w_vb, w_hs, w_vs, w_irq;
    logic [7:0]  w_fc;
`ifdef VTG_FLIP_EN
    logic        d_flip;
`endif

    video_timing_gen u_dut (
        .clk_sys(clk), .reset_n(d_rst_n), .ce_pix(d_ce),
`ifdef VTG_FLIP_EN
        .flip(d_flip),
`endif
        .rgb_in(d_rgb_in), .hpos(d_hpos), .vpos(d_vpos), .rgb_out(d_rgb_out),
        .hblank(d_hb), .vblank(d_vb), .hsync_n(d_hs), .vsync_n(d_vs),
        .vbl_irq(d_irq), .frame_cnt(d_fc)
    );

    video_timing_gen #(
        .CW(4), .RGBW(12), .H_ACTIVE(10), .H_SYNC_START(12), .H_SYNC_END(16), .H_TOTAL(16),
        .V_ACTIVE(5), .V_SYNC_START(6), .V_SYNC_END(7), .V_TOTAL(8)
    ) u_small (
        .clk_sys(clk), .reset_n(s_rst_n), .ce_pix(s_ce),
`ifdef VTG_FLIP_EN
        .flip(1'b0),
`endif
        .rgb_in(s_rgb_in), .hpos(s_hpos), .vpos(s_vpos), .rgb_out(s_rgb_out),
        .hblank(s_hb), .vblank(s_vb), .hsync_n(s_hs), .vsync_n(s_vs),
        .vbl_irq(s_irq), .frame_cnt(s_fc)
    );

    video_timing_gen #(
        .CW(10), .RGBW(12), .H_ACTIVE(512), .H_SYNC_START(540), .H_SYNC_END(600),
        .H_TOTAL(640), .V_ACTIVE(224), .V_SYNC_START(227), .V_SYNC_END(234), .V_TOTAL(262)
    ) u_wide (
        .clk_sys(clk), .reset_n(w_rst_n), .ce_pix(w_ce),
`ifdef VTG_FLIP_EN
        .flip(1'b0),
`endif
        .rgb_in(w_rgb_in), .hpos(w_hpos), .vpos(w_vpos), .rgb_out(w_rgb_out),
        .hblank(w_hb), .vblank(w_vb), .hsync_n(w_hs), .vsync_n(w_vs),
        .vbl_irq(w_irq), .frame_cnt(w_fc)
    );

    // Observed outputs packed as {hpos, vpos, hblank, vblank, hsync_n, vsync_n, rgb, irq, frame}
    logic [56:0] d_obs, s_obs, w_obs;
    assign d_obs = {16'(d_hpos), 16'(d_vpos), d_hb, d_vb, d_hs, d_vs, d_rgb_out, d_irq, d_fc};
    assign s_obs = {16'(s_hpos), 16'(s_vpos), s_hb, s_vb, s_hs, s_vs, s_rgb_out, s_irq, s_fc};
    assign w_obs = {16'(w_hpos), 16'(w_vpos), w_hb, w_vb, w_hs, w_vs, w_rgb_out, w_irq, w_fc};

    // Model state: pulses since reset, expected rgb_out, expected irq
    longint      d_t, s_t, w_t;
    logic [11:0] d_er, s_er, w_er;
    bit          d_ie, s_ie, w_ie;

    function automatic int h_of(geom_t g, longint t);
        return int'(t % longint'(g.ht));
    endfunction
    function automatic int v_of(geom_t g, longint t);
        return int'((t / longint'(g.ht)) % longint'(g.vt));
    endfunction
    function automatic int f_of(geom_t g, longint t);
        return int'((t / longint'(g.ht * g.vt)) % 256);
    endfunction
    function automatic bit blanked(geom_t g, longint t);
        return (h_of(g, t) >= g.ha) || (v_of(g, t) >= g.va);
    endfunction

    function automatic logic [56:0] exp_vec(geom_t g, longint t, logic [11:0] er, bit irq);
        int h, v;
        bit hb, vb, hs, vs;
        h  = h_of(g, t);
        v  = v_of(g, t);
        hb = (t == 0) || (h >= g.ha);
        vb = (t == 0) || (v >= g.va);
        hs = !(h >= g.hss && h < g.hse);
        vs = !(v >= g.vss && v < g.vse);
        return {16'(h), 16'(v), hb, vb, hs, vs, er, irq, 8'(f_of(g, t))};
    endfunction

    // One clk_sys of the model; reset flags are blank, so the very first pixel is dropped.
    task automatic model_step(input geom_t g, inout longint t, inout logic [11:0] er,
                              output bit irq, input bit ce, input logic [11:0] rgb);
        if (ce) begin
            er  = (t == 0 || blanked(g, t)) ? 12'h000 : rgb;
            t   = t + 1;
            irq = (h_of(g, t) == 0) && (v_of(g, t) == g.va);
        end else begin
            irq = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        d_rst_n = 1'b0; s_rst_n = 1'b0; w_rst_n = 1'b0;
        d_ce = 1'b0; s_ce = 1'b0; w_ce = 1'b0;
        d_rgb_in = 12'h0; s_rgb_in = 12'h0; w_rgb_in = 12'h0;
`ifdef VTG_FLIP_EN
        d_flip = 1'b0;
`endif
        d_t = 0; s_t = 0; w_t = 0; d_er = 0; s_er = 0; w_er = 0; d_ie = 0; s_ie = 0; w_ie = 0;
        tick();
        tick();
        checks++;
        if (d_obs !== exp_vec(g_def, 0, 12'h0, 1'b0))
            begin errors++; $display("FAIL reset_def got %h want %h", d_obs, exp_vec(g_def, 0, 0, 0)); end
        checks++;
        if (s_obs !== exp_vec(g_sml, 0, 12'h0, 1'b0))
            begin errors++; $display("FAIL reset_sml got %h want %h", s_obs, exp_vec(g_sml, 0, 0, 0)); end
        checks++;
        if (w_obs !== exp_vec(g_wid, 0, 12'h0, 1'b0))
            begin errors++; $display("FAIL reset_wid got %h want %h", w_obs, exp_vec(g_wid, 0, 0, 0)); end
        d_rst_n = 1'b1; s_rst_n = 1'b1; w_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_line();
        int hb_low, hs_low, hs_min, hs_max;
        hb_low = 0; hs_low = 0; hs_min = 9999; hs_max = -1;
        for (int i = 0; i < 384; i++) begin
            d_ce = 1'b1;
            d_rgb_in = 12'($urandom);
            model_step(g_def, d_t, d_er, d_ie, d_ce, d_rgb_in);
            tick();
            checks++;
            if (d_obs !== exp_vec(g_def, d_t, d_er, d_ie)) begin
                errors++;
                $display("FAIL line t=%0d got %h want %h", d_t, d_obs, exp_vec(g_def, d_t, d_er, d_ie));
            end
            if (!d_hb) hb_low++;
            if (!d_hs) begin
                hs_low++;
                if (int'(d_hpos) < hs_min) hs_min = int'(d_hpos);
                if (int'(d_hpos) > hs_max) hs_max = int'(d_hpos);
            end
        end
        d_ce = 1'b0;
        checks++;
        if (hb_low !== 288) begin errors++; $display("FAIL line_active got %0d want 288", hb_low); end
        checks++;
        if (hs_low !== 31 || hs_min !== 312 || hs_max !== 342) begin
            errors++;
            $display("FAIL line_hsync got %0d px %0d..%0d want 31 px 312..342", hs_low, hs_min, hs_max);
        end
        checks++;
        if (d_hpos !== 9'd0 || d_vpos !== 9'd1)
            begin errors++; $display("FAIL line_end got %0d,%0d want 0,1", d_hpos, d_vpos); end
    endtask

    task automatic test_ce_hold();
        for (int i = 0; i < 400; i++) begin
            d_ce = 1'($urandom_range(0, 1));
            d_rgb_in = 12'($urandom);
            model_step(g_def, d_t, d_er, d_ie, d_ce, d_rgb_in);
            tick();
            checks++;
            if (d_obs !== exp_vec(g_def, d_t, d_er, d_ie)) begin
                errors++;
                $display("FAIL ce_hold t=%0d got %h want %h", d_t, d_obs, exp_vec(g_def, d_t, d_er, d_ie));
            end
        end
        d_ce = 1'b0;
    endtask

    task automatic test_frame();
        int lit, irqs, vs_low;
        lit = 0; irqs = 0; vs_low = 0;
        for (int i = 0; i < 256; i++) begin
            s_ce = 1'b1;
            s_rgb_in = 12'hFFF;
            model_step(g_sml, s_t, s_er, s_ie, s_ce, s_rgb_in);
            tick();
            checks++;
            if (s_obs !== exp_vec(g_sml, s_t, s_er, s_ie)) begin
                errors++;
                $display("FAIL frame t=%0d got %h want %h", s_t, s_obs, exp_vec(g_sml, s_t, s_er, s_ie));
            end
            if (s_irq) irqs++;
            if (i >= 128 && s_rgb_out == 12'hFFF) lit++;
            if (i >= 128 && !s_vs) vs_low++;
            if (s_t == 80) begin
                checks++;
                if (s_vb !== 1'b1 || s_irq !== 1'b1 || s_vpos !== 4'd5)
                    begin errors++; $display("FAIL vbl_start got vb=%b irq=%b v=%0d want 1 1 5", s_vb, s_irq, s_vpos); end
            end
            if (s_t == 128) begin
                checks++;
                if (s_fc !== 8'd1 || s_vpos !== 4'd0 || s_hpos !== 4'd0 || s_vb !== 1'b0)
                    begin errors++; $display("FAIL frame_wrap got fc=%0d pos=%0d,%0d vb=%b want 1 0,0 0", s_fc, s_hpos, s_vpos, s_vb); end
            end
        end
        s_ce = 1'b0;
        checks++;
        if (lit !== 50) begin errors++; $display("FAIL lit_pixels got %0d want 50", lit); end
        checks++;
        if (irqs !== 2) begin errors++; $display("FAIL irq_count got %0d want 2", irqs); end
        checks++;
        if (vs_low !== 16) begin errors++; $display("FAIL vsync_len got %0d want 16", vs_low); end
    endtask

    task automatic test_reset_mid();
        int run, max_run, pulses;
        run = 0; max_run = 0; pulses = 0;
        for (int k = 0; k < 2000 && s_t != 311; k++) begin
            s_ce = (k % 4 == 0);
            s_rgb_in = 12'($urandom);
            model_step(g_sml, s_t, s_er, s_ie, s_ce, s_rgb_in);
            tick();
            checks++;
            if (s_obs !== exp_vec(g_sml, s_t, s_er, s_ie)) begin
                errors++;
                $display("FAIL pre_rst t=%0d got %h want %h", s_t, s_obs, exp_vec(g_sml, s_t, s_er, s_ie));
            end
        end
        s_ce = 1'b0;
        checks++;
        if (s_t != 311 || s_vpos !== 4'd3 || s_hpos !== 4'd7)
            begin errors++; $display("FAIL rst_point got t=%0d pos=%0d,%0d want 311 7,3", s_t, s_hpos, s_vpos); end
        #2 s_rst_n = 1'b0;
        #1;
        checks++;
        if (s_obs !== exp_vec(g_sml, 0, 12'h0, 1'b0))
            begin errors++; $display("FAIL async_rst got %h want %h", s_obs, exp_vec(g_sml, 0, 0, 0)); end
        s_t = 0; s_er = 12'h0; s_ie = 1'b0;
        tick();
        s_rst_n = 1'b1;
        for (int k = 0; k < 800; k++) begin
            s_ce = (k % 4 == 0);
            s_rgb_in = 12'($urandom);
            model_step(g_sml, s_t, s_er, s_ie, s_ce, s_rgb_in);
            tick();
            checks++;
            if (s_obs !== exp_vec(g_sml, s_t, s_er, s_ie)) begin
                errors++;
                $display("FAIL post_rst t=%0d got %h want %h", s_t, s_obs, exp_vec(g_sml, s_t, s_er, s_ie));
            end
            if (s_irq) begin
                run++;
                if (run == 1) pulses++;
            end else begin
                run = 0;
            end
            if (run > max_run) max_run = run;
        end
        s_ce = 1'b0;
        checks++;
        if (pulses !== 1 || max_run !== 1)
            begin errors++; $display("FAIL irq_width got %0d pulses width %0d want 1 width 1", pulses, max_run); end
    endtask

    task automatic test_frame_wrap();
        logic [7:0] fc_before;
        fc_before = 8'h0;
        s_rst_n = 1'b0;
        s_t = 0; s_er = 12'h0; s_ie = 1'b0;
        tick();
        s_rst_n = 1'b1;
        for (int i = 0; i < 256 * 128; i++) begin
            s_ce = 1'b1;
            s_rgb_in = 12'($urandom);
            fc_before = s_fc;
            model_step(g_sml, s_t, s_er, s_ie, s_ce, s_rgb_in);
            tick();
            checks++;
            if (s_obs !== exp_vec(g_sml, s_t, s_er, s_ie)) begin
                errors++;
                $display("FAIL wrap t=%0d got %h want %h", s_t, s_obs, exp_vec(g_sml, s_t, s_er, s_ie));
            end
        end
        s_ce = 1'b0;
        checks++;
        if (fc_before !== 8'd255 || s_fc !== 8'd0 || s_hpos !== 4'd0 || s_vpos !== 4'd0)
            begin errors++; $display("FAIL fc_255_to_0 got %0d->%0d want 255->0", fc_before, s_fc); end
    endtask

    task automatic test_wide();
        for (int i = 0; i < 641; i++) begin
            w_ce = 1'b1;
            w_rgb_in = 12'($urandom);
            model_step(g_wid, w_t, w_er, w_ie, w_ce, w_rgb_in);
            tick();
            checks++;
            if (w_obs !== exp_vec(g_wid, w_t, w_er, w_ie)) begin
                errors++;
                $display("FAIL wide t=%0d got %h want %h", w_t, w_obs, exp_vec(g_wid, w_t, w_er, w_ie));
            end
            if (w_t == 640) begin
                checks++;
                if (w_hpos !== 10'd0 || w_vpos !== 10'd1)
                    begin errors++; $display("FAIL wide_line got %0d,%0d want 0,1", w_hpos, w_vpos); end
            end
        end
        w_ce = 1'b0;
    endtask

`ifdef VTG_FLIP_EN
    task automatic test_flip();
        int eh, ev;
        d_rst_n = 1'b0;
        d_t = 0; d_er = 12'h0; d_ie = 1'b0;
        tick();
        d_rst_n = 1'b1;
        d_flip = 1'b1;
        #1;
        checks++;
        if (d_hpos !== 9'd287 || d_vpos !== 9'd223)
            begin errors++; $display("FAIL flip_origin got %0d,%0d want 287,223", d_hpos, d_vpos); end
        for (int i = 0; i < 300; i++) begin
            d_ce = 1'b1;
            d_flip = 1'($urandom_range(0, 1));
            model_step(g_def, d_t, d_er, d_ie, d_ce, 12'($urandom));
            tick();
            eh = h_of(g_def, d_t);
            ev = v_of(g_def, d_t);
            if (d_flip && eh < 288) eh = 287 - eh;
            if (d_flip && ev < 224) ev = 223 - ev;
            checks++;
            if (int'(d_hpos) != eh || int'(d_vpos) != ev)
                begin errors++; $display("FAIL flip_pos got %0d,%0d want %0d,%0d", d_hpos, d_vpos, eh, ev); end
        end
        d_ce = 1'b0;
        d_flip = 1'b1;
        #1;
        checks++;
        if (d_hpos !== 9'd300 || d_vpos !== 9'd223)
            begin errors++; $display("FAIL flip_blank got %0d,%0d want 300,223", d_hpos, d_vpos); end
        d_flip = 1'b0;
        #1;
        checks++;
        if (d_hpos !== 9'd300 || d_vpos !== 9'd0)
            begin errors++; $display("FAIL flip_off got %0d,%0d want 300,0", d_hpos, d_vpos); end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        g_def = '{ha: 288, hss: 312, hse: 343, ht: 384, va: 224, vss: 227, vse: 234, vt: 263};
        g_sml = '{ha: 10, hss: 12, hse: 16, ht: 16, va: 5, vss: 6, vse: 7, vt: 8};
        g_wid = '{ha: 512, hss: 540, hse: 600, ht: 640, va: 224, vss: 227, vse: 234, vt: 262};
        #3;
        test_reset();
        test_line();
        test_ce_hold();
        test_frame();
        test_reset_mid();
        test_frame_wrap();
        test_wide();
`ifdef VTG_FLIP_EN
        test_flip();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
